// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: scoreboard hazard controller for the ID stage of a 5-stage MIPS pipeline.
// Counts in-flight GPR writes and stalls on RAW hazards. Flushes IF/ID on a taken redirect.
// Drains the pipeline on request.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   id_*                   decoded ID-stage instruction (valid, sources, destination, redirect)
//   wb_wr, wb_dst          register-file write in WB this cycle
//   drain_req              level request to stop issuing until the pipeline is empty
//   pc_stall, ifid_stall   hold PC / IF/ID
//   ifid_flush             zero IF/ID on the next edge
//   idex_bubble            load a NOP into ID/EX on the next edge
//   issue                  ID instruction advances into EX this cycle
//   drained                no instruction in flight and issue is blocked
module id_hazard_ctrl #(
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wr,
  input  logic [AW-1:0] id_dst,
  input  logic          id_redirect,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_dst,
  input  logic          drain_req,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          issue,
  output logic          drained
);

  localparam int unsigned NREG = 2 ** AW;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_STALL   = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DRAINED = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt     [1:NREG-1];
  logic [CW-1:0] w_cnt_nxt [1:NREG-1];
  logic [CW-1:0] w_cnt     [0:NREG-1];
  logic          w_inc     [1:NREG-1];
  logic          w_dec     [1:NREG-1];
  logic          w_all_zero;
  logic          w_byp_rs, w_byp_rt, w_haz_rs, w_haz_rt, w_hazard;
  logic          w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_bubble, w_issue, w_drained;

  // Readable view of the scoreboard; $0 reads as never pending.
  always_comb begin
    w_cnt[0] = '0;
    for (int r = 1; r < int'(NREG); r++) w_cnt[r] = r_cnt[r];
  end

  // RAW check; a same-cycle WB write to the source is bypassed by the transparent RegFile.
  always_comb begin
    w_byp_rs = wb_wr & (wb_dst == id_rs);
    w_byp_rt = wb_wr & (wb_dst == id_rt);
    w_haz_rs = id_use_rs & (id_rs != '0) & (w_cnt[id_rs] != CW'(w_byp_rs));
    w_haz_rt = id_use_rt & (id_rt != '0) & (w_cnt[id_rt] != CW'(w_byp_rt));
    w_hazard = id_valid & (w_haz_rs | w_haz_rt);
  end

  // Empty once this cycle's WB retires the last writer; no issue happens while draining.
  always_comb begin
    w_all_zero = 1'b1;
    for (int r = 1; r < int'(NREG); r++) begin
      if (!((r_cnt[r] == '0) ||
            ((r_cnt[r] == CNT_ONE) && wb_wr && (wb_dst == AW'(r)))))
        w_all_zero = 1'b0;
    end
  end

  // Next-state and unreset output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_issue       = 1'b0;
    w_drained     = 1'b0;
    case (r_state)
      S_RUN, S_STALL: begin
        if (w_hazard) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
          w_state_nxt   = S_STALL;
        end else begin
          w_issue       = id_valid & ~drain_req;
          w_ifid_flush  = w_issue & id_redirect;
          w_idex_bubble = ~w_issue;
          w_pc_stall    = drain_req;
          w_ifid_stall  = drain_req;
          w_state_nxt   = drain_req ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_bubble = 1'b1;
        if (w_all_zero) w_state_nxt = S_DRAINED;
      end
      default: begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_bubble = 1'b1;
        w_drained     = 1'b1;
        if (!drain_req) w_state_nxt = S_RUN;
      end
    endcase
  end

  // Outputs clear as soon as reset asserts, without waiting for an edge.
  assign pc_stall    = w_pc_stall    & ~rst;
  assign ifid_stall  = w_ifid_stall  & ~rst;
  assign ifid_flush  = w_ifid_flush  & ~rst;
  assign idex_bubble = w_idex_bubble & ~rst;
  assign issue       = w_issue       & ~rst;
  assign drained     = w_drained     & ~rst;

  // Counter update; an illegal step holds the value instead of wrapping.
  always_comb begin
    for (int r = 1; r < int'(NREG); r++) begin
      w_inc[r]     = w_issue & id_wr & (id_dst == AW'(r));
      w_dec[r]     = wb_wr & (wb_dst == AW'(r));
      w_cnt_nxt[r] = r_cnt[r];
      if (w_inc[r] && !w_dec[r] && (r_cnt[r] != CNT_MAX))
        w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
      else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0))
        w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      for (int r = 1; r < int'(NREG); r++) r_cnt[r] <= '0;
    end else begin
      r_state <= w_state_nxt;
      for (int r = 1; r < int'(NREG); r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  // Protocol checks: a counter step past either end means the pipeline lost track of a writer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 1; r < int'(NREG); r++) begin
        assert (!(w_inc[r] && !w_dec[r] && (r_cnt[r] == CNT_MAX)))
          else $error("id_hazard_ctrl: in-flight counter overflow on r%0d", r);
        assert (!(w_dec[r] && !w_inc[r] && (r_cnt[r] == '0)))
          else $error("id_hazard_ctrl: in-flight counter underflow on r%0d", r);
      end
    end
  end

endmodule
